// File: rtl/mdu_sched.sv
// Round-robin scheduler sharing one multi-cycle mul/div unit between two requesters.
// Holds op/operands stable while the unit runs and routes the result back to the owner.
module mdu_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [6:0]  req0_op,
  input  logic [31:0] req0_src1,
  input  logic [31:0] req0_src2,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [6:0]  req1_op,
  input  logic [31:0] req1_src1,
  input  logic [31:0] req1_src2,
  output logic        req1_ready,
  input  logic        flush0,
  input  logic        flush1,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [6:0]  mdu_op,
  output logic [31:0] mdu_src1,
  output logic [31:0] mdu_src2,
  input  logic        mdu_complete,
  input  logic [31:0] mdu_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_owner;
  logic        r_lastGrant;
  logic [6:0]  r_op;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [31:0] r_res;

  logic        w_cand0;
  logic        w_cand1;
  logic        w_grant;
  logic        w_accept;
  logic        w_ownerFlush;
  logic        w_ownerRspReady;
  logic [6:0]  w_reqOp;
  logic [31:0] w_reqSrc1;
  logic [31:0] w_reqSrc2;

  // On a tie the requester that did not win last time gets the unit.
  assign w_cand0   = req0_valid & ~flush0;
  assign w_cand1   = req1_valid & ~flush1;
  assign w_grant   = (w_cand0 & w_cand1) ? ~r_lastGrant : w_cand1;
  assign w_accept  = (r_state == IDLE) & (w_cand0 | w_cand1) & ~reset;
  assign w_reqOp   = w_grant ? req1_op   : req0_op;
  assign w_reqSrc1 = w_grant ? req1_src1 : req0_src1;
  assign w_reqSrc2 = w_grant ? req1_src2 : req0_src2;

  assign req0_ready = w_accept & ~w_grant & ~flush0;
  assign req1_ready = w_accept &  w_grant & ~flush1;

  assign w_ownerFlush    = r_owner ? flush1     : flush0;
  assign w_ownerRspReady = r_owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_nextState = (w_reqOp != 7'd0) ? BUSY : RESP;
      BUSY: begin
        if (mdu_complete && w_ownerFlush) w_nextState = IDLE;
        else if (mdu_complete)            w_nextState = RESP;
        else if (w_ownerFlush)            w_nextState = DRAIN;
      end
      // A flushed op cannot be aborted; wait it out without responding.
      DRAIN: if (mdu_complete) w_nextState = IDLE;
      RESP:  if (w_ownerRspReady || w_ownerFlush) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The unit only sees an op while it is actually computing.
  always_comb begin
    mdu_op     = 7'd0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (r_state != IDLE);
    if (r_state == BUSY || r_state == DRAIN) mdu_op = r_op;
    if (r_state == RESP) begin
      rsp0_valid = ~r_owner;
      rsp1_valid =  r_owner;
    end
  end

  assign mdu_src1   = r_src1;
  assign mdu_src2   = r_src2;
  assign rsp_result = r_res;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_op        <= 7'd0;
      r_src1      <= 32'd0;
      r_src2      <= 32'd0;
      r_res       <= 32'd0;
    end else if (w_accept) begin
      r_owner     <= w_grant;
      r_lastGrant <= w_grant;
      r_op        <= w_reqOp;
      r_src1      <= w_reqSrc1;
      r_src2      <= w_reqSrc2;
      if (w_reqOp == 7'd0) r_res <= 32'd0;
    end else if (r_state == BUSY && mdu_complete && !w_ownerFlush) begin
      r_res <= mdu_result;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// Directed bench for mdu_sched: the bench plays the mul/div unit and scoreboards
// expected responses per requester.
module tb_mdu_sched;

  localparam logic [6:0] OP_MUL   = 7'b0000001;
  localparam logic [6:0] OP_MULHU = 7'b0000100;
  localparam logic [6:0] OP_DIV   = 7'b0001000;
  localparam logic [6:0] OP_DIVU  = 7'b0010000;
  localparam logic [6:0] OP_MOD   = 7'b0100000;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [6:0]  req0_op, req1_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic        req0_ready, req1_ready;
  logic        flush0, flush1;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp0_ready, rsp1_ready;
  logic [6:0]  mdu_op;
  logic [31:0] mdu_src1, mdu_src2;
  logic        mdu_complete;
  logic [31:0] mdu_result;
  logic        busy;

  typedef struct {
    logic        owner;
    logic [31:0] result;
  } exp_t;

  exp_t scoreboard[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  mdu_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_ready(req1_ready),
    .flush0(flush0), .flush1(flush1),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .mdu_op(mdu_op), .mdu_src1(mdu_src1), .mdu_src2(mdu_src2),
    .mdu_complete(mdu_complete), .mdu_result(mdu_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for the emulated unit (divisors are never zero here).
  function automatic logic [31:0] refCalc(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prodU;
    logic signed [63:0] prodS;
    prodU = {32'd0, a} * {32'd0, b};
    prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      7'b0000001: refCalc = prodU[31:0];
      7'b0000010: refCalc = prodS[63:32];
      7'b0000100: refCalc = prodU[63:32];
      7'b0001000: refCalc = (b == 0) ? 32'hFFFFFFFF : $signed(a) / $signed(b);
      7'b0010000: refCalc = (b == 0) ? 32'hFFFFFFFF : a / b;
      7'b0100000: refCalc = (b == 0) ? a : $signed(a) % $signed(b);
      7'b1000000: refCalc = (b == 0) ? a : a % b;
      default:    refCalc = 32'hDEADBEEF;
    endcase
  endfunction

  assign mdu_result = refCalc(mdu_op, mdu_src1, mdu_src2);

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic [6:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    if (idx == 0) begin
      req0_valid = valid; req0_op = op; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = valid; req1_op = op; req1_src1 = a; req1_src2 = b;
    end
  endtask

  task automatic expectAccept(input int idx, input logic [6:0] op, input logic [31:0] a,
                              input logic [31:0] b, input bit willRespond);
    exp_t e;
    checkOutput($sformatf("req0_ready_acc%0d", idx), {31'd0, req0_ready}, {31'd0, idx == 0});
    checkOutput($sformatf("req1_ready_acc%0d", idx), {31'd0, req1_ready}, {31'd0, idx == 1});
    if (willRespond) begin
      e.owner  = (idx == 1);
      e.result = (op == 7'd0) ? 32'd0 : refCalc(op, a, b);
      scoreboard.push_back(e);
    end
  endtask

  task automatic expectRsp(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL %s observed=response expected=empty_scoreboard_entry", tag);
    end else begin
      e = scoreboard.pop_front();
      checkOutput({tag, "_v0"}, {31'd0, rsp0_valid}, {31'd0, ~e.owner});
      checkOutput({tag, "_v1"}, {31'd0, rsp1_valid}, {31'd0, e.owner});
      checkOutput({tag, "_res"}, rsp_result, e.result);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    applyStimulus(1, 1'b0, 7'd0, 32'd0, 32'd0);
    flush0 = 1'b0; flush1 = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    mdu_complete = 1'b0;

    // Reset values, ready suppressed while reset is high
    nextCycle();
    nextCycle();
    applyStimulus(0, 1'b1, OP_MUL, 32'd3, 32'd3);
    settle();
    checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
    checkOutput("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("rst_result", rsp_result, 32'd0);
    checkOutput("rst_mdu_op", {25'd0, mdu_op}, 32'd0);
    checkOutput("rst_src1", mdu_src1, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    // Tie from reset: div 100/7 vs mod 100/7, requester 0 first
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b1, OP_DIV, 32'd100, 32'd7);
    applyStimulus(1, 1'b1, OP_MOD, 32'd100, 32'd7);
    settle();
    expectAccept(0, OP_DIV, 32'd100, 32'd7, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    checkOutput("div_mdu_op", {25'd0, mdu_op}, {25'd0, OP_DIV});
    checkOutput("div_src1", mdu_src1, 32'd100);
    checkOutput("div_src2", mdu_src2, 32'd7);
    checkOutput("div_busy", {31'd0, busy}, 32'd1);
    checkOutput("div_ready1_busy", {31'd0, req1_ready}, 32'd0);
    nextCycle();
    mdu_complete = 1'b1;
    settle();
    checkOutput("div_op_at_cmpl", {25'd0, mdu_op}, {25'd0, OP_DIV});
    nextCycle();
    mdu_complete = 1'b0;
    settle();
    expectRsp("div_rsp");
    checkOutput("div_op_in_rsp", {25'd0, mdu_op}, 32'd0);
    checkOutput("div_ready1_rsp", {31'd0, req1_ready}, 32'd0);
    rsp0_ready = 1'b1;
    nextCycle();
    rsp0_ready = 1'b0;
    settle();
    expectAccept(1, OP_MOD, 32'd100, 32'd7, 1'b1);
    nextCycle();
    applyStimulus(1, 1'b0, 7'd0, 32'd0, 32'd0);
    mdu_complete = 1'b1;
    settle();
    checkOutput("mod_mdu_op", {25'd0, mdu_op}, {25'd0, OP_MOD});
    nextCycle();
    mdu_complete = 1'b0;
    settle();
    expectRsp("mod_rsp");
    rsp1_ready = 1'b1;
    nextCycle();
    rsp1_ready = 1'b0;

    // Next tie goes back to requester 0: mul 7*6 at minimum spacing
    applyStimulus(0, 1'b1, OP_MUL, 32'd7, 32'd6);
    applyStimulus(1, 1'b1, OP_DIVU, 32'd1000, 32'd10);
    settle();
    expectAccept(0, OP_MUL, 32'd7, 32'd6, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    checkOutput("mul_op_t1", {25'd0, mdu_op}, {25'd0, OP_MUL});
    nextCycle();
    mdu_complete = 1'b1;
    settle();
    checkOutput("mul_op_t2", {25'd0, mdu_op}, {25'd0, OP_MUL});
    nextCycle();
    mdu_complete = 1'b0;
    settle();
    expectRsp("mul_rsp");
    checkOutput("mul_op_t3", {25'd0, mdu_op}, 32'd0);
    rsp0_ready = 1'b1;
    nextCycle();
    rsp0_ready = 1'b0;

    // Requester 1 divu, flushed two cycles after accept, unit finishes 30 cycles later
    settle();
    expectAccept(1, OP_DIVU, 32'd1000, 32'd10, 1'b0);
    nextCycle();
    applyStimulus(1, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    checkOutput("divu_op", {25'd0, mdu_op}, {25'd0, OP_DIVU});
    nextCycle();
    flush1 = 1'b1;
    settle();
    nextCycle();
    flush1 = 1'b0;
    applyStimulus(0, 1'b1, OP_MUL, 32'd3, 32'd5);
    settle();
    for (int i = 0; i < 29; i++) begin
      checkOutput("drain_op", {25'd0, mdu_op}, {25'd0, OP_DIVU});
      checkOutput("drain_rsp1", {31'd0, rsp1_valid}, 32'd0);
      checkOutput("drain_ready0", {31'd0, req0_ready}, 32'd0);
      nextCycle();
      settle();
    end
    mdu_complete = 1'b1;
    settle();
    checkOutput("drain_op_cmpl", {25'd0, mdu_op}, {25'd0, OP_DIVU});
    checkOutput("drain_busy_cmpl", {31'd0, busy}, 32'd1);
    nextCycle();
    mdu_complete = 1'b0;
    settle();
    checkOutput("drain_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("drain_no_rsp1", {31'd0, rsp1_valid}, 32'd0);
    expectAccept(0, OP_MUL, 32'd3, 32'd5, 1'b0);

    // Owner flush in the same cycle as completion drops the result
    nextCycle();
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    checkOutput("fc_op", {25'd0, mdu_op}, {25'd0, OP_MUL});
    nextCycle();
    mdu_complete = 1'b1;
    flush0 = 1'b1;
    settle();
    nextCycle();
    mdu_complete = 1'b0;
    flush0 = 1'b0;
    settle();
    checkOutput("fc_busy", {31'd0, busy}, 32'd0);
    checkOutput("fc_rsp0", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("fc_op_idle", {25'd0, mdu_op}, 32'd0);

    // Response held for 5 stalled cycles while requester 1 waits
    applyStimulus(0, 1'b1, OP_MULHU, 32'hFFFFFFFF, 32'd2);
    settle();
    expectAccept(0, OP_MULHU, 32'hFFFFFFFF, 32'd2, 1'b1);
    nextCycle();
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    applyStimulus(1, 1'b1, OP_MUL, 32'd9, 32'd9);
    settle();
    nextCycle();
    mdu_complete = 1'b1;
    settle();
    nextCycle();
    mdu_complete = 1'b0;
    settle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_rsp0", {31'd0, rsp0_valid}, 32'd1);
      checkOutput("stall_result", rsp_result, 32'd1);
      checkOutput("stall_ready1", {31'd0, req1_ready}, 32'd0);
      nextCycle();
      settle();
    end
    expectRsp("stall_rsp");
    rsp0_ready = 1'b1;
    nextCycle();
    rsp0_ready = 1'b0;
    settle();
    expectAccept(1, OP_MUL, 32'd9, 32'd9, 1'b1);

    // Reset in the middle of BUSY
    nextCycle();
    applyStimulus(1, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    checkOutput("rb_src1", mdu_src1, 32'd9);
    nextCycle();
    reset = 1'b1;
    settle();
    nextCycle();
    reset = 1'b0;
    scoreboard.delete();
    applyStimulus(0, 1'b1, 7'd0, 32'd11, 32'd12);
    applyStimulus(1, 1'b1, OP_MUL, 32'd2, 32'd2);
    settle();
    checkOutput("rb_busy", {31'd0, busy}, 32'd0);
    checkOutput("rb_mdu_op", {25'd0, mdu_op}, 32'd0);
    checkOutput("rb_src1_zero", mdu_src1, 32'd0);
    checkOutput("rb_src2_zero", mdu_src2, 32'd0);
    checkOutput("rb_result", rsp_result, 32'd0);
    checkOutput("rb_rsp1", {31'd0, rsp1_valid}, 32'd0);
    expectAccept(0, 7'd0, 32'd11, 32'd12, 1'b1);

    // op==0 responds the very next cycle without touching the unit
    nextCycle();
    applyStimulus(0, 1'b0, 7'd0, 32'd0, 32'd0);
    applyStimulus(1, 1'b0, 7'd0, 32'd0, 32'd0);
    settle();
    expectRsp("zero_rsp");
    checkOutput("zero_mdu_op", {25'd0, mdu_op}, 32'd0);
    rsp0_ready = 1'b1;
    nextCycle();
    rsp0_ready = 1'b0;
    settle();
    checkOutput("zero_busy", {31'd0, busy}, 32'd0);
    checkOutput("sb_empty", scoreboard.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Scheduler that shares the single multi-cycle multiply/divide resource (the `mul`/`div` path behind the ALU's `complete` handshake) between two requesters, e.g. two execute-stage issue slots. It arbitrates round-robin, registers and holds operands and op for the full duration of the operation, and returns the result to the owning requester through a valid/ready response. It also handles per-requester flushes, including a flush that arrives while the unit cannot be aborted.

## Interface
Parameters:
- none (widths fixed: 32-bit operands, 7-bit one-hot op `{modu,mod,divu,div,mulhu,mulh,mul}`, bit 0 = mul)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_op / req1_op  in  7  one-hot mul/div op
- req0_src1, req0_src2 / req1_src1, req1_src2  in  32  operands
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- flush0 / flush1  in  1  cancel the requester's outstanding or presented op
- rsp0_valid / rsp1_valid  out  1  result available
- rsp_result  out  32  result (shared bus, qualified by rspN_valid)
- rsp0_ready / rsp1_ready  in  1  requester takes result
- mdu_op  out  7  op to unit; non-zero only in BUSY/DRAIN
- mdu_src1, mdu_src2  out  32  held operands
- mdu_complete  in  1  one-cycle completion pulse from unit
- mdu_result  in  32  unit result, valid with mdu_complete
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, DRAIN, RESP. Registers: state, owner, last_grant, op_q, src1_q, src2_q, res_q.
- IDLE: grant = requester with valid and ~flush; if both, the one != last_grant. reqN_ready = (state==IDLE) & grant==N & ~flushN & ~reset; only one ready high per cycle.
- Accept: latch op/src, owner<=N, last_grant<=N. op non-zero -> BUSY; op==0 -> RESP with res_q=0 (unit untouched).
- Op with >1 bit set: undefined; requesters must not issue.
- BUSY: mdu_op=op_q, mdu_src=src_q held stable. On mdu_complete: res_q<=mdu_result, -> RESP. flush of owner (without complete) -> DRAIN. Complete and owner flush same cycle -> IDLE, result discarded.
- DRAIN: mdu_op held until mdu_complete, then -> IDLE; no response raised. Flushes of either requester ignored.
- RESP: rsp<owner>_valid=1, rsp_result=res_q, held until rsp<owner>_ready -> IDLE. Owner flush in RESP -> IDLE, response dropped (valid may be seen that cycle; requester must ignore it).
- mdu_op is 0 in IDLE and RESP, so the unit sees op drop the cycle after complete (required: mul unit's complete toggles if op held).
- Flush of the non-owner: no effect except suppressing its own ready.
- reset: state=IDLE, last_grant=1 (requester 0 wins first tie), op_q=0, res_q=0.

## Timing
- Reset values: reqN_ready=0 while reset high, rspN_valid=0, rsp_result=0, mdu_op=0, mdu_src1/2=0, busy=0.
- Accept at cycle T -> mdu_op non-zero from T+1.
- mdu_complete at cycle C -> rspN_valid from C+1; ready at C+1 -> IDLE at C+2, next accept possible at C+2.
- Minimum request-to-request spacing for multiply (unit completes 1 cycle after op): accept T, complete T+2, rsp T+3, next accept T+4.
- op==0: accept T, rsp T+1.
- No new request accepted while busy; requester stalls on ready.

## Test plan
- req0 mul 7*6 alone -> ready0 at T, mdu_op=0000001 T+1..T+2, rsp0_valid T+3 with rsp_result=42; mdu_op=0 at T+3.
- req0 and req1 valid together from reset, div 100/7 and mod 100/7 -> req0 first (result 14), then req1 (result 2); next tie grants req0 again.
- req1 divu, flush1 two cycles after accept, unit completes 30 cycles later -> mdu_op held through completion, no rsp1_valid, busy drops cycle after complete, then req0 accepted.
- flush0 in same cycle as mdu_complete -> no rsp0_valid, IDLE next cycle.
- rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp_result stable, req1_ready stays 0, then IDLE.
- reset asserted mid-BUSY -> next cycle all outputs at reset values, last_grant=1.
